// File: rtl/aq_gemac_arp_resp.sv
// ARP responder for the Giga Ethernet MAC.
// Pops each complete frame from the MAC RX buffer and checks it for an ARP
// request for the local IP. A matching request produces a 60-byte ARP reply,
// which is written to the MAC TX buffer as REPLY_WORDS 32-bit words.
// Ports:
//   CLK, RST_N          system clock, synchronous active-low reset
//   ENABLE              accept new frames (only looked at in IDLE)
//   MAC_ADDRESS         local MAC; wire byte k = bits [8k+7:8k]
//   IP_ADDRESS          local IP, same byte order
//   RX_BUFF_*           RX pop port (data valid the cycle after RE)
//   TX_BUFF_*           TX write port (START/END qualify WE)
//   REPLY_COUNT         replies sent (wraps)
//   DROP_COUNT          frames discarded (wraps)
// Handshakes: RX_BUFF_RE pops one word only while RX_BUFF_EMPTY=0, and that
// word is taken from RX_BUFF_DATA one cycle later. TX_BUFF_WE is only raised
// while TX_BUFF_FULL=0, and a word counts as written on every cycle WE=1.
module aq_gemac_arp_resp #(
    parameter int REPLY_WORDS = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic [47:0] MAC_ADDRESS,
    input  logic [31:0] IP_ADDRESS,
    output logic        RX_BUFF_RE,
    input  logic [31:0] RX_BUFF_DATA,
    input  logic        RX_BUFF_EMPTY,
    input  logic        RX_BUFF_VALID,
    input  logic [15:0] RX_BUFF_LENGTH,
    input  logic [15:0] RX_BUFF_STATUS,
    output logic        TX_BUFF_WE,
    output logic        TX_BUFF_START,
    output logic        TX_BUFF_END,
    input  logic        TX_BUFF_READY,
    output logic [31:0] TX_BUFF_DATA,
    input  logic        TX_BUFF_FULL,
    input  logic [9:0]  TX_BUFF_SPACE,
    output logic [15:0] REPLY_COUNT,
    output logic [15:0] DROP_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CHECK, S_WAIT_TX, S_SEND
    } state_t;

    localparam logic [9:0] SPACE_NEED = 10'(REPLY_WORDS);
    localparam logic [3:0] LAST_IDX   = 4'(REPLY_WORDS - 1);

    state_t      state_q, state_d;
    logic [14:0] words_q, words_d;
    logic [14:0] issued_q, issued_d;
    logic [14:0] rcv_q, rcv_d;
    logic        rd_pend_q, rd_pend_d;
    logic        status_ok_q, status_ok_d;
    logic        len_ok_q, len_ok_d;
    logic        type_ok_q, type_ok_d;
    logic        proto_ok_q, proto_ok_d;
    logic        oper_ok_q, oper_ok_d;
    logic [15:0] tpa_lo_q, tpa_lo_d;
    logic [15:0] tpa_hi_q, tpa_hi_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] reply_cnt_q, reply_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic [16:0] len_sum;
    logic [14:0] len_words;
    logic [31:0] reply_word;
    logic        re, we, start, last;
    logic [31:0] tx_data;

    // Frame length rounded up to whole words; a zero length still pops one.
    assign len_sum   = {1'b0, RX_BUFF_LENGTH} + 17'd3;
    assign len_words = len_sum[16:2];

    always_comb begin
        reply_word = '0;
        case (idx_q)
            4'd0:    reply_word = sha_q[31:0];
            4'd1:    reply_word = {MAC_ADDRESS[15:0], sha_q[47:32]};
            4'd2:    reply_word = MAC_ADDRESS[47:16];
            4'd3:    reply_word = 32'h01000608;
            4'd4:    reply_word = 32'h04060008;
            4'd5:    reply_word = {MAC_ADDRESS[15:0], 16'h0200};
            4'd6:    reply_word = MAC_ADDRESS[47:16];
            4'd7:    reply_word = IP_ADDRESS;
            4'd8:    reply_word = sha_q[31:0];
            4'd9:    reply_word = {spa_q[15:0], sha_q[47:32]};
            4'd10:   reply_word = {16'h0000, spa_q[31:16]};
            default: reply_word = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        issued_d    = issued_q;
        rcv_d       = rcv_q;
        rd_pend_d   = 1'b0;
        status_ok_d = status_ok_q;
        len_ok_d    = len_ok_q;
        type_ok_d   = type_ok_q;
        proto_ok_d  = proto_ok_q;
        oper_ok_d   = oper_ok_q;
        tpa_lo_d    = tpa_lo_q;
        tpa_hi_d    = tpa_hi_q;
        sha_d       = sha_q;
        spa_d       = spa_q;
        idx_d       = idx_q;
        reply_cnt_d = reply_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        re          = 1'b0;
        we          = 1'b0;
        start       = 1'b0;
        last        = 1'b0;
        tx_data     = '0;

        case (state_q)
            S_IDLE: begin
                if (ENABLE && RX_BUFF_VALID) begin
                    words_d     = (len_words == 15'd0) ? 15'd1 : len_words;
                    status_ok_d = (RX_BUFF_STATUS == 16'h0000);
                    len_ok_d    = (RX_BUFF_LENGTH >= 16'd42);
                    issued_d    = '0;
                    rcv_d       = '0;
                    type_ok_d   = 1'b0;
                    proto_ok_d  = 1'b0;
                    oper_ok_d   = 1'b0;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                re        = (issued_q < words_q) && !RX_BUFF_EMPTY;
                rd_pend_d = re;
                if (re) issued_d = issued_q + 15'd1;
                // The word popped last cycle is on RX_BUFF_DATA now.
                if (rd_pend_q) begin
                    case (rcv_q)
                        15'd3:  type_ok_d  = (RX_BUFF_DATA == 32'h01000608);
                        15'd4:  proto_ok_d = (RX_BUFF_DATA == 32'h04060008);
                        15'd5: begin
                            oper_ok_d     = (RX_BUFF_DATA[15:0] == 16'h0100);
                            sha_d[15:0]   = RX_BUFF_DATA[31:16];
                        end
                        15'd6:  sha_d[47:16] = RX_BUFF_DATA;
                        15'd7:  spa_d        = RX_BUFF_DATA;
                        15'd9:  tpa_lo_d     = RX_BUFF_DATA[31:16];
                        15'd10: tpa_hi_d     = RX_BUFF_DATA[15:0];
                        default: ;
                    endcase
                    rcv_d = rcv_q + 15'd1;
                    if (rcv_q + 15'd1 == words_q) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // len_ok guarantees every checked word was actually captured.
                if (status_ok_q && len_ok_q && type_ok_q && proto_ok_q &&
                    oper_ok_q && ({tpa_hi_q, tpa_lo_q} == IP_ADDRESS)) begin
                    state_d = S_WAIT_TX;
                end else begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            S_WAIT_TX: begin
                if (TX_BUFF_READY && !TX_BUFF_FULL && (TX_BUFF_SPACE >= SPACE_NEED)) begin
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                tx_data = reply_word;
                if (!TX_BUFF_FULL) begin
                    we    = 1'b1;
                    start = (idx_q == 4'd0);
                    last  = (idx_q == LAST_IDX);
                    if (last) begin
                        reply_cnt_d = reply_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            words_q     <= '0;
            issued_q    <= '0;
            rcv_q       <= '0;
            rd_pend_q   <= 1'b0;
            status_ok_q <= 1'b0;
            len_ok_q    <= 1'b0;
            type_ok_q   <= 1'b0;
            proto_ok_q  <= 1'b0;
            oper_ok_q   <= 1'b0;
            tpa_lo_q    <= '0;
            tpa_hi_q    <= '0;
            sha_q       <= '0;
            spa_q       <= '0;
            idx_q       <= '0;
            reply_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            issued_q    <= issued_d;
            rcv_q       <= rcv_d;
            rd_pend_q   <= rd_pend_d;
            status_ok_q <= status_ok_d;
            len_ok_q    <= len_ok_d;
            type_ok_q   <= type_ok_d;
            proto_ok_q  <= proto_ok_d;
            oper_ok_q   <= oper_ok_d;
            tpa_lo_q    <= tpa_lo_d;
            tpa_hi_q    <= tpa_hi_d;
            sha_q       <= sha_d;
            spa_q       <= spa_d;
            idx_q       <= idx_d;
            reply_cnt_q <= reply_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign RX_BUFF_RE    = re;
    assign TX_BUFF_WE    = we;
    assign TX_BUFF_START = start;
    assign TX_BUFF_END   = last;
    assign TX_BUFF_DATA  = tx_data;
    assign REPLY_COUNT   = reply_cnt_q;
    assign DROP_COUNT    = drop_cnt_q;

endmodule

// File: tb/tb_aq_gemac_arp_resp.sv
module tb_aq_gemac_arp_resp;

  localparam logic [47:0] LOC_MAC = 48'h554433221100;
  localparam logic [31:0] LOC_IP  = 32'h5A00A8C0;
  localparam logic [47:0] PEER_SHA = 48'h010000000002;
  localparam logic [31:0] PEER_SPA = 32'h1A00A8C0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #4 clk = ~clk;
  logic rst_n = 1'b0;

  logic        enable = 1'b1;
  logic        rx_re;
  logic [31:0] rx_data = '0;
  logic        rx_empty;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_len = '0;
  logic [15:0] rx_status = '0;
  logic        tx_we, tx_start, tx_end;
  logic        tx_ready = 1'b1;
  logic [31:0] tx_data;
  logic        tx_full = 1'b0;
  logic [9:0]  tx_space = 10'd512;
  logic [15:0] reply_count, drop_count;

  aq_gemac_arp_resp #(.REPLY_WORDS(15)) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable),
    .MAC_ADDRESS(LOC_MAC), .IP_ADDRESS(LOC_IP),
    .RX_BUFF_RE(rx_re), .RX_BUFF_DATA(rx_data), .RX_BUFF_EMPTY(rx_empty),
    .RX_BUFF_VALID(rx_valid), .RX_BUFF_LENGTH(rx_len), .RX_BUFF_STATUS(rx_status),
    .TX_BUFF_WE(tx_we), .TX_BUFF_START(tx_start), .TX_BUFF_END(tx_end),
    .TX_BUFF_READY(tx_ready), .TX_BUFF_DATA(tx_data), .TX_BUFF_FULL(tx_full),
    .TX_BUFF_SPACE(tx_space), .REPLY_COUNT(reply_count), .DROP_COUNT(drop_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RX buffer model ----------------
  logic [31:0] rx_mem [0:255];
  int rx_rd = 0;
  int rx_avail = 0;
  assign rx_empty = (rx_rd >= rx_avail);
  always @(posedge clk) begin
    if (rx_re) begin
      rx_data <= rx_mem[rx_rd[7:0]];
      rx_rd   <= rx_rd + 1;
    end
  end

  // ---------------- monitor ----------------
  logic [33:0] obs_mem [0:255];
  int obs_cyc [0:255];
  int obs_wr = 0;
  int re_cnt = 0;
  int last_re_cyc = 0;
  always @(negedge clk) begin
    if (rx_re) begin
      re_cnt      <= re_cnt + 1;
      last_re_cyc <= cyc;
    end
    if (tx_we) begin
      obs_mem[obs_wr[7:0]] <= {tx_start, tx_end, tx_data};
      obs_cyc[obs_wr[7:0]] <= cyc;
      obs_wr <= obs_wr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int obs_rd = 0;
  logic [15:0] exp_reply = '0;
  logic [15:0] exp_drop = '0;

  function automatic logic [31:0] req_word(int i, logic [47:0] sha, logic [31:0] spa,
                                           logic [31:0] tpa);
    case (i)
      0:  return 32'hFFFFFFFF;
      1:  return {sha[15:0], 16'hFFFF};
      2:  return sha[47:16];
      3:  return 32'h01000608;
      4:  return 32'h04060008;
      5:  return {sha[15:0], 16'h0100};
      6:  return sha[47:16];
      7:  return spa;
      8:  return 32'h0;
      9:  return {tpa[15:0], 16'h0000};
      10: return {16'h0000, tpa[31:16]};
      default: return 32'h0;
    endcase
  endfunction

  // Reply layout: Ethernet header then ARP reply, little-endian byte lanes.
  function automatic logic [31:0] rep_word(int i, logic [47:0] sha, logic [31:0] spa);
    case (i)
      0:  return sha[31:0];
      1:  return {LOC_MAC[15:0], sha[47:32]};
      2:  return LOC_MAC[47:16];
      3:  return 32'h01000608;
      4:  return 32'h04060008;
      5:  return {LOC_MAC[15:0], 16'h0200};
      6:  return LOC_MAC[47:16];
      7:  return LOC_IP;
      8:  return sha[31:0];
      9:  return {spa[15:0], sha[47:32]};
      10: return {16'h0000, spa[31:16]};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_frame(input logic [31:0] tpa, input int nwords);
    for (int i = 0; i < nwords; i++)
      rx_mem[(rx_avail + i) & 255] = req_word(i, PEER_SHA, PEER_SPA, tpa);
    rx_avail = rx_avail + nwords;
  endtask

  task automatic start_frame(input logic [15:0] len, input logic [15:0] status);
    rx_len    = len;
    rx_status = status;
    rx_valid  = 1'b1;
    @(posedge clk); #1;
    rx_valid  = 1'b0;
  endtask

  task automatic push_reply();
    for (int i = 0; i < 15; i++)
      exp_q.push_back({(i == 0), (i == 14), rep_word(i, PEER_SHA, PEER_SPA)});
  endtask

  task automatic wait_counts(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (reply_count == exp_reply && drop_count == exp_drop) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rx_re, tx_we, tx_start, tx_end} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {rx_re, tx_we, tx_start, tx_end});
    end
    checks++;
    if (tx_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h want 00000000", tx_data);
    end
    checks++;
    if (reply_count !== 16'h0 || drop_count !== 16'h0) begin
      errors++; $display("FAIL reset_counts got %h/%h want 0/0", reply_count, drop_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_valid_request();
    int re0, first;
    bit ok;
    re0 = re_cnt;
    first = obs_wr;
    load_frame(LOC_IP, 15);
    start_frame(16'd60, 16'h0);
    push_reply();
    exp_reply = exp_reply + 16'd1;
    wait_counts(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL valid_done got %0d want %0d", reply_count, exp_reply); end
    checks++;
    if (re_cnt - re0 != 15) begin errors++; $display("FAIL valid_pops got %0d want 15", re_cnt - re0); end
    while (exp_q.size() > 0) begin
      logic [33:0] e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr) begin
        errors++; $display("FAIL valid_word missing want %h", e);
      end else begin
        if (obs_mem[obs_rd[7:0]] !== e) begin
          errors++; $display("FAIL valid_word%0d got %h want %h", obs_rd - first, obs_mem[obs_rd[7:0]], e);
        end
        obs_rd++;
      end
    end
    checks++;
    if (obs_wr != first + 15) begin errors++; $display("FAIL valid_we_count got %0d want 15", obs_wr - first); end
    checks++;
    if (obs_cyc[(first + 14) & 255] - obs_cyc[first & 255] != 14) begin
      errors++; $display("FAIL valid_consecutive got %0d want 14", obs_cyc[(first + 14) & 255] - obs_cyc[first & 255]);
    end
    checks++;
    if (obs_cyc[first & 255] - last_re_cyc != 4) begin
      errors++; $display("FAIL valid_latency got %0d want 4", obs_cyc[first & 255] - last_re_cyc);
    end
    checks++;
    if (reply_count !== 16'd1) begin errors++; $display("FAIL valid_reply_count got %0d want 1", reply_count); end
    obs_rd = obs_wr;
  endtask

  task automatic test_wrong_tpa();
    int re0, w0;
    bit ok;
    re0 = re_cnt;
    w0 = obs_wr;
    load_frame(32'h5B00A8C0, 15);
    start_frame(16'd60, 16'h0);
    exp_drop = exp_drop + 16'd1;
    wait_counts(200, ok);
    repeat (4) @(posedge clk);
    checks++;
    if (!ok || drop_count !== 16'd1) begin errors++; $display("FAIL tpa_drop got %0d want 1", drop_count); end
    checks++;
    if (re_cnt - re0 != 15) begin errors++; $display("FAIL tpa_pops got %0d want 15", re_cnt - re0); end
    checks++;
    if (obs_wr != w0) begin errors++; $display("FAIL tpa_no_we got %0d want 0", obs_wr - w0); end
  endtask

  task automatic test_bad_status_len();
    int re0, w0;
    bit ok;
    re0 = re_cnt;
    w0 = obs_wr;
    load_frame(LOC_IP, 15);
    start_frame(16'd60, 16'h0001);
    exp_drop = exp_drop + 16'd1;
    wait_counts(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL status_drop got %0d want %0d", drop_count, exp_drop); end
    load_frame(LOC_IP, 10);
    start_frame(16'd40, 16'h0);
    exp_drop = exp_drop + 16'd1;
    wait_counts(200, ok);
    repeat (4) @(posedge clk);
    checks++;
    if (!ok || drop_count !== exp_drop) begin errors++; $display("FAIL len_drop got %0d want %0d", drop_count, exp_drop); end
    checks++;
    if (re_cnt - re0 != 25) begin errors++; $display("FAIL statlen_pops got %0d want 25", re_cnt - re0); end
    checks++;
    if (obs_wr != w0) begin errors++; $display("FAIL statlen_no_we got %0d want 0", obs_wr - w0); end
  endtask

  task automatic test_space_wait();
    int re0, re1, first;
    bit ok;
    re0 = re_cnt;
    first = obs_wr;
    tx_space = 10'd14;
    load_frame(LOC_IP, 15);
    start_frame(16'd60, 16'h0);
    push_reply();
    exp_reply = exp_reply + 16'd1;
    for (int n = 0; n < 100 && re_cnt < re0 + 15; n++) @(posedge clk);
    // Extra words sit in the RX buffer while the reply is held back.
    load_frame(32'h0, 4);
    re1 = re_cnt;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs_wr != first) begin errors++; $display("FAIL space_early_we got %0d want 0", obs_wr - first); end
    checks++;
    if (re_cnt != re1 || re1 - re0 != 15) begin
      errors++; $display("FAIL space_no_re got %0d want 15", re_cnt - re0);
    end
    tx_space = 10'd15;
    wait_counts(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL space_done got %0d want %0d", reply_count, exp_reply); end
    while (exp_q.size() > 0) begin
      logic [33:0] e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr) begin
        errors++; $display("FAIL space_word missing want %h", e);
      end else begin
        if (obs_mem[obs_rd[7:0]] !== e) begin
          errors++; $display("FAIL space_word%0d got %h want %h", obs_rd - first, obs_mem[obs_rd[7:0]], e);
        end
        obs_rd++;
      end
    end
    obs_rd = obs_wr;
    rx_avail = rx_rd;
    tx_space = 10'd512;
  endtask

  task automatic test_full_stall();
    int first;
    bit ok;
    first = obs_wr;
    load_frame(LOC_IP, 15);
    start_frame(16'd60, 16'h0);
    push_reply();
    exp_reply = exp_reply + 16'd1;
    for (int n = 0; n < 200 && obs_wr < first + 6; n++) @(posedge clk);
    #1 tx_full = 1'b1;
    repeat (3) @(posedge clk);
    #1 tx_full = 1'b0;
    wait_counts(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_done got %0d want %0d", reply_count, exp_reply); end
    checks++;
    if (obs_cyc[(first + 6) & 255] - obs_cyc[(first + 5) & 255] != 4) begin
      errors++; $display("FAIL stall_gap got %0d want 4", obs_cyc[(first + 6) & 255] - obs_cyc[(first + 5) & 255]);
    end
    checks++;
    if (obs_wr != first + 15) begin errors++; $display("FAIL stall_we_count got %0d want 15", obs_wr - first); end
    while (exp_q.size() > 0) begin
      logic [33:0] e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr) begin
        errors++; $display("FAIL stall_word missing want %h", e);
      end else begin
        if (obs_mem[obs_rd[7:0]] !== e) begin
          errors++; $display("FAIL stall_word%0d got %h want %h", obs_rd - first, obs_mem[obs_rd[7:0]], e);
        end
        obs_rd++;
      end
    end
    obs_rd = obs_wr;
  endtask

  task automatic test_reset_mid();
    int re0, first;
    bit ok;
    re0 = re_cnt;
    load_frame(LOC_IP, 15);
    start_frame(16'd60, 16'h0);
    for (int n = 0; n < 100 && re_cnt < re0 + 5; n++) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rx_re, tx_we, tx_start, tx_end, tx_data, reply_count, drop_count} !== '0) begin
      errors++; $display("FAIL midreset_outputs got %b/%h/%h/%h want zeros",
                         {rx_re, tx_we, tx_start, tx_end}, tx_data, reply_count, drop_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_reply = '0;
    exp_drop  = '0;
    rx_avail  = rx_rd;
    @(posedge clk); #1;
    first = obs_wr;
    load_frame(LOC_IP, 15);
    start_frame(16'd60, 16'h0);
    push_reply();
    exp_reply = exp_reply + 16'd1;
    wait_counts(200, ok);
    checks++;
    if (!ok || reply_count !== 16'd1) begin errors++; $display("FAIL midreset_count got %0d want 1", reply_count); end
    while (exp_q.size() > 0) begin
      logic [33:0] e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr) begin
        errors++; $display("FAIL midreset_word missing want %h", e);
      end else begin
        if (obs_mem[obs_rd[7:0]] !== e) begin
          errors++; $display("FAIL midreset_word%0d got %h want %h", obs_rd - first, obs_mem[obs_rd[7:0]], e);
        end
        obs_rd++;
      end
    end
    obs_rd = obs_wr;
  endtask

  initial begin
    test_reset();
    test_valid_request();
    test_wrong_tpa();
    test_bad_status_len();
    test_space_wait();
    test_full_stall();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
